// File: rtl/uart_tx_stim.sv
// UART transmitter with byte FIFO: serialises 8N1/8E1/8O1 frames at CLKS_PER_BIT clocks per bit.
// States: IDLE = line high, waiting | START = start bit | DATA = 8 data bits | PARITY = parity bit | STOP = stop bit(s)
module uart_tx_stim #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_AW      = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               frame_done
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]    BAUD_ONE  = BW'(1);
    localparam logic [FIFO_AW:0] CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] CNT_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic             ODD_BIT   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              state, state_nxt;
    logic [7:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
    logic [BW-1:0]       baud_cnt, baud_nxt;
    logic [2:0]          bit_cnt, bit_nxt;
    logic [7:0]          shift, shift_nxt;
    logic                par_bit, par_nxt;
    logic                tx_nxt, done_nxt;
    logic                push, pop, fifo_empty, bit_end;

    assign din_ready  = (fifo_count != CNT_FULL);
    assign push       = din_valid & din_ready;
    assign fifo_empty = (fifo_count == '0);
    assign busy       = (state != IDLE) | !fifo_empty;
    assign bit_end    = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_nxt;
            bit_cnt    <= bit_nxt;
            shift      <= shift_nxt;
            par_bit    <= par_nxt;
            tx         <= tx_nxt;
            frame_done <= done_nxt;
        end
    end

    // tx is computed one cycle ahead so the line changes exactly on the bit boundary
    always_comb begin
        state_nxt = state;
        baud_nxt  = bit_end ? '0 : baud_cnt + BAUD_ONE;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        par_nxt   = par_bit;
        tx_nxt    = tx;
        done_nxt  = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt   = 1'b1;
                baud_nxt = '0;
                pop      = !fifo_empty;
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                    tx_nxt    = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = shift >> 1;
                    if (bit_cnt == 3'd7) begin
                        bit_nxt = '0;
                        if (PARITY_EN != 0) begin
                            state_nxt = PARITY;
                            tx_nxt    = par_bit;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                        tx_nxt  = shift[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    bit_nxt   = '0;
                    tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                        tx_nxt    = 1'b1;
                        pop       = !fifo_empty;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
        // a pop always starts a new frame, whether from IDLE or straight out of STOP
        if (pop) begin
            shift_nxt = mem[rd_ptr];
            par_nxt   = (^mem[rd_ptr]) ^ ODD_BIT;
            state_nxt = START;
            baud_nxt  = '0;
            bit_nxt   = '0;
            tx_nxt    = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_stim.sv
// Directed bench for uart_tx_stim: four instances cover 8N1, 8E1, 8O1 and 8N2 framing.
module tb_uart_tx_stim;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;

    logic       valid_a = 0, valid_b = 0, valid_c = 0, valid_d = 0;
    logic       ready_a, ready_b, ready_c, ready_d;
    logic       tx_a, tx_b, tx_c, tx_d;
    logic       busy_a, busy_b, busy_c, busy_d;
    logic [2:0] cnt_a, cnt_b, cnt_c, cnt_d;
    logic       done_a, done_b, done_c, done_d;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    uart_tx_stim #(.CLKS_PER_BIT(4), .FIFO_AW(2)) dut_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(valid_a), .din_ready(ready_a),
        .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a), .frame_done(done_a));

    uart_tx_stim #(.CLKS_PER_BIT(4), .FIFO_AW(2), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(valid_b), .din_ready(ready_b),
        .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b), .frame_done(done_b));

    uart_tx_stim #(.CLKS_PER_BIT(4), .FIFO_AW(2), .PARITY_EN(1), .PARITY_ODD(1)) dut_c (
        .clk(clk), .rst(rst), .din(din), .din_valid(valid_c), .din_ready(ready_c),
        .tx(tx_c), .busy(busy_c), .fifo_count(cnt_c), .frame_done(done_c));

    uart_tx_stim #(.CLKS_PER_BIT(4), .FIFO_AW(2), .STOP_BITS(2)) dut_d (
        .clk(clk), .rst(rst), .din(din), .din_valid(valid_d), .din_ready(ready_d),
        .tx(tx_d), .busy(busy_d), .fifo_count(cnt_d), .frame_done(done_d));

    // advance to just after the next rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int idle_err = 0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx_a !== 1'b1 || tx_b !== 1'b1 || tx_c !== 1'b1 || tx_d !== 1'b1 || busy_a !== 1'b0)
                idle_err++;
        end
        total++; if (tx_a !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx_a); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else passed++;
        total++; if (ready_a !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_a); else passed++;
        total++; if (cnt_a !== 3'd0) $display("FAIL reset_count: got %0d want 0", cnt_a); else passed++;
        total++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b want 0", done_a); else passed++;
        total++; if (idle_err != 0) $display("FAIL reset_idle100: got %0d bad cycles want 0", idle_err); else passed++;
    endtask

    task automatic test_single_frame;
        logic [7:0] b = 8'h55;
        logic       exp;
        int         bit_err = 0, done_err = 0, k;
        din = b; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        total++; if (tx_a !== 1'b1) $display("FAIL single_tx_at_push: got %b want 1", tx_a); else passed++;
        total++; if (cnt_a !== 3'd1) $display("FAIL single_count_at_push: got %0d want 1", cnt_a); else passed++;
        for (int i = 1; i <= 40; i++) begin
            tick();
            k = (i - 1) / 4;
            exp = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            if (tx_a !== exp) begin
                if (bit_err == 0) $display("FAIL single_bits: cycle %0d got %b want %b", i, tx_a, exp);
                bit_err++;
            end
            if (done_a !== 1'b0) done_err++;
        end
        total++; if (bit_err != 0) $display("FAIL single_bits_total: got %0d bad cycles want 0", bit_err); else passed++;
        total++; if (done_err != 0) $display("FAIL single_done_early: got %0d pulses want 0", done_err); else passed++;
        tick();
        total++; if (done_a !== 1'b1) $display("FAIL single_done: got %b want 1", done_a); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL single_busy_after: got %b want 0", busy_a); else passed++;
        tick();
        total++; if (done_a !== 1'b0) $display("FAIL single_done_width: got %b want 0", done_a); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [5] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
        logic       exp_bits [200];
        logic [7:0] cur;
        logic       prev_ready;
        int         idx = 0, bit_err = 0, dones = 0, max_cnt = 0;
        logic [2:0] cnt41 = '0, cnt42 = '0;
        logic       ready41 = 1'b1;
        for (int f = 0; f < 5; f++) begin
            cur = bytes[f];
            for (int b = 0; b < 10; b++)
                exp_bits[f*40 + b*4 + 0] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur[b-1];
            for (int b = 0; b < 10; b++)
                for (int c = 1; c < 4; c++)
                    exp_bits[f*40 + b*4 + c] = exp_bits[f*40 + b*4];
        end
        din = bytes[0]; valid_a = 1'b1; prev_ready = ready_a;
        for (int cyc = 1; cyc <= 210; cyc++) begin
            tick();
            if (valid_a && prev_ready) idx++;
            if (idx < 5) din = bytes[idx]; else valid_a = 1'b0;
            prev_ready = ready_a;
            if (int'(cnt_a) > max_cnt) max_cnt = int'(cnt_a);
            if (cyc == 41) begin cnt41 = cnt_a; ready41 = ready_a; end
            if (cyc == 42) cnt42 = cnt_a;
            if (done_a === 1'b1) dones++;
            if (cyc >= 2 && cyc <= 201 && tx_a !== exp_bits[cyc-2]) begin
                if (bit_err == 0) $display("FAIL b2b_bits: cycle %0d got %b want %b", cyc, tx_a, exp_bits[cyc-2]);
                bit_err++;
            end
        end
        total++; if (max_cnt != 4) $display("FAIL b2b_max_count: got %0d want 4", max_cnt); else passed++;
        total++; if (cnt41 !== 3'd4) $display("FAIL b2b_full_count: got %0d want 4", cnt41); else passed++;
        total++; if (ready41 !== 1'b0) $display("FAIL b2b_full_ready: got %b want 0", ready41); else passed++;
        total++; if (cnt42 !== 3'd3) $display("FAIL b2b_after_pop: got %0d want 3", cnt42); else passed++;
        total++; if (bit_err != 0) $display("FAIL b2b_bits_total: got %0d bad cycles want 0", bit_err); else passed++;
        total++; if (dones != 5) $display("FAIL b2b_frames: got %0d want 5", dones); else passed++;
        total++; if (busy_a !== 1'b0 || tx_a !== 1'b1) $display("FAIL b2b_idle_end: got busy=%b tx=%b want 0/1", busy_a, tx_a); else passed++;
    endtask

    task automatic test_parity;
        din = 8'h07; valid_b = 1'b1; valid_c = 1'b1;
        tick();
        valid_b = 1'b0; valid_c = 1'b0;
        for (int i = 1; i <= 46; i++) begin
            tick();
            if (i == 37) begin
                total++; if (tx_b !== 1'b1) $display("FAIL parity_even: got %b want 1", tx_b); else passed++;
                total++; if (tx_c !== 1'b0) $display("FAIL parity_odd: got %b want 0", tx_c); else passed++;
            end
            if (i == 41) begin
                total++; if (tx_b !== 1'b1 || tx_c !== 1'b1) $display("FAIL parity_stop: got %b%b want 11", tx_b, tx_c); else passed++;
            end
            if (i == 44) begin
                total++; if (done_b !== 1'b0) $display("FAIL parity_done_early: got %b want 0", done_b); else passed++;
            end
            if (i == 45) begin
                total++; if (done_b !== 1'b1 || done_c !== 1'b1) $display("FAIL parity_len44: got %b%b want 11", done_b, done_c); else passed++;
            end
        end
    endtask

    task automatic test_two_stop;
        logic tx_hist [47];
        int   ones = 0;
        din = 8'h00; valid_d = 1'b1;
        tick();
        tick();
        valid_d = 1'b0;
        for (int i = 2; i <= 46; i++) begin
            tick();
            tx_hist[i] = tx_d;
        end
        for (int i = 37; i <= 44; i++)
            if (tx_hist[i] === 1'b1) ones++;
        total++; if (tx_hist[36] !== 1'b0) $display("FAIL stop2_last_data: got %b want 0", tx_hist[36]); else passed++;
        total++; if (ones != 8) $display("FAIL stop2_high_len: got %0d want 8", ones); else passed++;
        total++; if (tx_hist[45] !== 1'b0) $display("FAIL stop2_second_start: got %b want 0", tx_hist[45]); else passed++;
        repeat (50) tick();
        total++; if (busy_d !== 1'b0) $display("FAIL stop2_idle_end: got %b want 0", busy_d); else passed++;
    endtask

    task automatic test_reset_mid_frame;
        int post_err = 0;
        valid_a = 1'b1;
        din = 8'hF0; tick();
        din = 8'h12; tick();
        din = 8'h34; tick();
        valid_a = 1'b0;
        repeat (16) tick();
        total++; if (tx_a !== 1'b0) $display("FAIL rstmid_bit3: got %b want 0", tx_a); else passed++;
        total++; if (cnt_a !== 3'd2) $display("FAIL rstmid_queued: got %0d want 2", cnt_a); else passed++;
        rst = 1'b1;
        #1;
        total++; if (tx_a !== 1'b1) $display("FAIL rstmid_tx: got %b want 1", tx_a); else passed++;
        total++; if (cnt_a !== 3'd0) $display("FAIL rstmid_count: got %0d want 0", cnt_a); else passed++;
        total++; if (busy_a !== 1'b0 || ready_a !== 1'b1) $display("FAIL rstmid_flags: got busy=%b ready=%b want 0/1", busy_a, ready_a); else passed++;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (tx_a !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b0) post_err++;
        end
        total++; if (post_err != 0) $display("FAIL rstmid_no_frame: got %0d bad cycles want 0", post_err); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_parity();
        test_two_stop();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
